// File: rtl/food_tile_engine.sv
// food_tile_engine: per-tile pellet map with level init sweep, eat/score tracking and a 2-stage pellet render path.
// Optional feature macro POWER_PELLET_EN: four blinking +50 power pellets and the power_pulse output.

module food_tile_engine #(
  parameter int COLS  = 28,
  parameter int ROWS  = 30,
  parameter int X_OFF = 208,
  parameter int Y_OFF = 0
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        new_level,
  output logic [4:0]  wall_qx,
  output logic [4:0]  wall_qy,
  input  logic        wall_q,
  input  logic        pac_valid,
  input  logic [4:0]  pac_tx,
  input  logic [4:0]  pac_ty,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [3:0]  food_addr,
  input  logic [7:0]  food_data,
  output logic        pellet_on,
  output logic        eat_pulse,
  output logic [9:0]  remaining,
  output logic [15:0] score,
  output logic        init_done,
  output logic        level_clear
`ifdef POWER_PELLET_EN
  ,
  output logic        power_pulse
`endif
);

  localparam int NTILES = COLS * ROWS;
  localparam int IW     = $clog2(NTILES);

  localparam logic [4:0]  COLS5   = 5'(COLS);
  localparam logic [4:0]  ROWS5   = 5'(ROWS);
  localparam logic [10:0] X_OFF11 = 11'(X_OFF);
  localparam logic [10:0] Y_OFF11 = 11'(Y_OFF);
  localparam logic [9:0]  MAZE_W  = 10'(8 * COLS);
  localparam logic [9:0]  MAZE_H  = 10'(16 * ROWS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NTILES - 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_CLEARED
  } state_t;

  state_t            state;
  logic [NTILES-1:0] present;
  logic [IW-1:0]     sweep_idx;

`ifdef POWER_PELLET_EN
  localparam logic [IW-1:0] PP0 = IW'(3 * COLS + 1);
  localparam logic [IW-1:0] PP1 = IW'(3 * COLS + COLS - 2);
  localparam logic [IW-1:0] PP2 = IW'((ROWS - 8) * COLS + 1);
  localparam logic [IW-1:0] PP3 = IW'((ROWS - 8) * COLS + COLS - 2);

  function automatic logic is_power(input logic [IW-1:0] idx);
    return (idx == PP0) || (idx == PP1) || (idx == PP2) || (idx == PP3);
  endfunction

  logic [23:0] blink_cnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) blink_cnt <= '0;
    else          blink_cnt <= blink_cnt + 24'd1;
  end
`endif

  // ---------------------------------------------------------------------------
  // Eat decode: Pac-Man's tile, its range check and the saturating score step
  // ---------------------------------------------------------------------------
  logic          pac_in_range;
  logic [IW-1:0] pac_idx;
  logic          eat_hit;
  logic [15:0]   eat_points;
  logic [16:0]   score_sum;
  logic [15:0]   score_next;
  logic [9:0]    rem_sweep;

  assign pac_in_range = (pac_tx < COLS5) && (pac_ty < ROWS5);
  assign pac_idx      = IW'(pac_ty) * IW'(COLS) + IW'(pac_tx);
  assign eat_hit      = pac_valid && pac_in_range && present[pac_idx];

`ifdef POWER_PELLET_EN
  assign eat_points = is_power(pac_idx) ? 16'd50 : 16'd10;
`else
  assign eat_points = 16'd10;
`endif

  assign score_sum  = {1'b0, score} + {1'b0, eat_points};
  assign score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  assign rem_sweep  = remaining + {9'd0, ~wall_q};

  // ---------------------------------------------------------------------------
  // Level FSM: INIT sweep fills the map, RUN clears pellets, CLEARED holds
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= S_INIT;
      // NOTE: the map is plain flops, not a RAM, so it can and must clear on reset.
      present     <= '0;
      sweep_idx   <= '0;
      wall_qx     <= '0;
      wall_qy     <= '0;
      remaining   <= '0;
      score       <= '0;
      eat_pulse   <= 1'b0;
      init_done   <= 1'b0;
      level_clear <= 1'b0;
`ifdef POWER_PELLET_EN
      power_pulse <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking throughout so every branch reads pre-edge state.
      eat_pulse <= 1'b0;
`ifdef POWER_PELLET_EN
      power_pulse <= 1'b0;
`endif
      if (new_level) begin
        state       <= S_INIT;
        present     <= '0;
        sweep_idx   <= '0;
        wall_qx     <= '0;
        wall_qy     <= '0;
        remaining   <= '0;
        init_done   <= 1'b0;
        level_clear <= 1'b0;
      end else begin
        case (state)
          S_INIT: begin
            present[sweep_idx] <= ~wall_q;
            remaining          <= rem_sweep;
            if (sweep_idx == LAST_IDX) begin
              state       <= (rem_sweep == '0) ? S_CLEARED : S_RUN;
              init_done   <= 1'b1;
              level_clear <= (rem_sweep == '0);
            end else begin
              sweep_idx <= sweep_idx + 1'b1;
              if (wall_qx == COLS5 - 5'd1) begin
                wall_qx <= '0;
                wall_qy <= wall_qy + 5'd1;
              end else begin
                wall_qx <= wall_qx + 5'd1;
              end
            end
          end
          S_RUN: begin
            if (eat_hit) begin
              present[pac_idx] <= 1'b0;
              remaining        <= remaining - 10'd1;
              score            <= score_next;
              eat_pulse        <= 1'b1;
`ifdef POWER_PELLET_EN
              power_pulse      <= is_power(pac_idx);
`endif
              if (remaining == 10'd1) begin
                state       <= S_CLEARED;
                level_clear <= 1'b1;
              end
            end
          end
          S_CLEARED: ;
          default: state <= S_INIT;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Render pipeline: S0 address, S1 tile lookup, S2 bitmap pixel select
  // ---------------------------------------------------------------------------
  logic [10:0]   dx;
  logic [10:0]   dy;
  logic          in_maze;
  logic [IW-1:0] pix_idx;
  logic          blink_ok;
  logic          in_maze_q;
  logic          present_q;
  logic [2:0]    col_q;
  logic [7:0]    food_q;

  // Bit 10 is the borrow: set when the pixel lies left of / above the maze.
  assign dx        = {1'b0, DrawX} - X_OFF11;
  assign dy        = {1'b0, DrawY} - Y_OFF11;
  assign food_addr = dy[3:0];
  assign in_maze   = !dx[10] && (dx[9:0] < MAZE_W) && !dy[10] && (dy[9:0] < MAZE_H);
  assign pix_idx   = IW'(dy[9:4]) * IW'(COLS) + IW'(dx[9:3]);

`ifdef POWER_PELLET_EN
  assign blink_ok = !is_power(pix_idx) || blink_cnt[23];
`else
  assign blink_ok = 1'b1;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      in_maze_q <= 1'b0;
      present_q <= 1'b0;
      col_q     <= '0;
      food_q    <= '0;
      pellet_on <= 1'b0;
    end else begin
      in_maze_q <= in_maze && (state != S_INIT);
      present_q <= in_maze && present[pix_idx] && blink_ok;
      col_q     <= dx[2:0];
      food_q    <= food_data;
      pellet_on <= in_maze_q && present_q && food_q[3'd7 - col_q];
    end
  end

endmodule
